// File: rtl/multi_word_adder_ctrl.sv
// Wide add/subtract sequencer: one N-bit adder is reused over WORDS clocks,
// least-significant word first, with the carry chained through a register.
module multi_bit_full_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         carry_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, carry_i};
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is held until then. Input side: in_valid/in_ready (ready
// only in IDLE). Output side: out_valid/out_ready (valid only in DONE).
module multi_word_adder_ctrl #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_sub,
  input  logic               in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic               out_carry,
  output logic               out_overflow,
  output logic [1:0]         dbg_state_o
);
  localparam int W  = N * WORDS;
  localparam int KW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [N-1:0]    a_w, b_w, s_w;
  logic            c_w;

  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k_q == KW'(i)) begin
        a_w = a_q[i*N +: N];
        b_w = b_q[i*N +: N];
      end
    end
  end

  multi_bit_full_adder #(.N(N)) u_adder (
    .a_i     (a_w),
    .b_i     (b_w),
    .carry_i (carry_q),
    .sum_o   (s_w),
    .carry_o (c_w)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub | in_carry;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (k_q == KW'(i)) sum_d[i*N +: N] = s_w;
        end
        carry_d = c_w;
        if (k_q == KW'(WORDS - 1)) begin
          cout_d  = c_w;
          // signed overflow: like-signed operands produced an opposite-signed sum
          ovf_d   = (a_w[N-1] == b_w[N-1]) & (s_w[N-1] != a_w[N-1]);
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_sum      = sum_q;
  assign out_carry    = cout_q;
  assign out_overflow = ovf_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_multi_word_adder_ctrl.sv
// Directed and random checks of multi_word_adder_ctrl (N=8, WORDS=4) against
// a 32-bit arithmetic reference model with an expected-result queue.
module tb_multi_word_adder_ctrl;
  localparam int N = 8;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         in_carry = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_overflow;
  logic [1:0]   dbg_state;

  // {carry, overflow, sum}
  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  multi_word_adder_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         c0;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    return {r[W], (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]), r[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
    int t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_carry = cin;
    step();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom); in_carry = 1'($urandom);
    exp_q.push_back(model(a, b, sub, cin));
  endtask

  task automatic wait_result();
    logic [W+1:0] e;
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      check("busy_in_ready", in_ready, 0);
      step(); cnt++;
    end
    check("latency", cnt, WORDS);
    check("sb_size", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("out_sum", out_sum, e[W-1:0]);
      check("out_overflow", out_overflow, e[W]);
      check("out_carry", out_carry, e[W+1]);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_done_valid", out_valid, 0);
    check("post_done_ready", in_ready, 1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    accept(a, b, sub, cin);
    wait_result();
    release_out();
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra, rb;
    // reset asserted mid-cycle, held 3 cycles
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1);
    do_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);

    // backpressure with new requests offered during DONE
    accept(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b1);
    wait_result();
    held = out_sum;
    in_valid = 1'b1; in_a = 32'hCAFEF00D; in_b = 32'h0BADF00D; in_sub = 1'b1; in_carry = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum_stable", out_sum, held);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    exp_q.push_back(model(32'hCAFEF00D, 32'h0BADF00D, 1'b1, 1'b0));
    wait_result();
    release_out();

    // reset while k == 2
    accept(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", dbg_state, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", out_sum, 0);
    check("midrst_carry", out_carry, 0);
    check("midrst_ovf", out_overflow, 0);
    void'(exp_q.pop_front());
    @(negedge clk) rst_n = 1'b1;
    step();
    check("midrst_no_pulse", out_valid, 0);
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);

    // random operations; sometimes out_ready is already high when DONE is entered
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFFFFFF;
        1: rb = 32'h80000000;
        default: ;
      endcase
      accept(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b1;
        wait_result();
        step();
        out_ready = 1'b0;
        check("done_one_cycle", out_valid, 0);
      end else begin
        wait_result();
        release_out();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
